// File: rtl/regfile_dump_streamer.sv
// Debug read-out engine: walks register-file entries first_reg..last_reg and streams them out.
// Optional REGDUMP_SKIP_ZERO_EN: zero-valued registers are skipped instead of emitted.
module regfile_dump_streamer #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_reg,
  input  logic [ADDR_WIDTH-1:0] last_reg,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  input  logic [DATA_WIDTH-1:0] rf_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] cur;
  logic [ADDR_WIDTH-1:0] end_idx;
  logic                  at_end;
  logic                  skip_word;

  assign at_end = (cur == end_idx);

`ifdef REGDUMP_SKIP_ZERO_EN
  assign skip_word = (rf_data == '0);
`else
  assign skip_word = 1'b0;
`endif

  // The read port always points at the walk cursor; it is only meaningful during READ.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur       <= '0;
      end_idx   <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cur     <= first_reg;
            end_idx <= last_reg;
            state   <= READ;
          end
        end
        READ: begin
          if (skip_word) begin
            if (at_end) begin
              state <= FIN;
            end else begin
              cur <= cur + 1'b1;
            end
          end else begin
            out_data  <= rf_data;
            out_index <= cur;
            out_last  <= at_end;
            state     <= SEND;
          end
        end
        SEND: begin
          // Cursor increment wraps naturally at the top of the register file.
          if (out_ready) begin
            if (out_last) begin
              state <= FIN;
            end else begin
              cur   <= cur + 1'b1;
              state <= READ;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign rf_addr   = cur;
  assign out_valid = (state == SEND);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

endmodule

// File: tb/tb_regfile_dump_streamer.sv
// Scoreboard bench for regfile_dump_streamer: directed dumps with expected words queued up front.
module tb_regfile_dump_streamer;

  typedef struct {
    logic [4:0]  idx;
    logic [63:0] data;
    logic        last;
  } word_t;

  logic        clock;
  logic        reset;
  logic        start;
  logic [4:0]  first_reg;
  logic [4:0]  last_reg;
  logic [4:0]  rf_addr;
  logic [63:0] rf_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [4:0]  out_index;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [63:0] regs [32];
  word_t       sb [$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          done_count = 0;
  int          done_cycle = 0;
  int          last_hs_cycle = 0;

  regfile_dump_streamer #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
    .clock(clock), .reset(reset), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .rf_addr(rf_addr), .rf_data(rf_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
  );

  assign rf_data = regs[rf_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every handshake pops one expected word from the scoreboard.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_word: got idx=%0d data=%0h last=%0b, required none", out_index, out_data, out_last);
      end else begin
        word_t w;
        w = sb.pop_front();
        if (out_index !== w.idx || out_data !== w.data || out_last !== w.last) begin
          bad++;
          $display("[TB] FAIL word: got idx=%0d data=%0h last=%0b, required idx=%0d data=%0h last=%0b",
                   out_index, out_data, out_last, w.idx, w.data, w.last);
        end
        if (out_last) last_hs_cycle = cyc;
      end
    end
    if (done) begin
      done_count++;
      done_cycle = cyc;
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic pushWord(input logic [4:0] idx, input logic [63:0] data, input logic last);
    word_t w;
    w.idx = idx;
    w.data = data;
    w.last = last;
    sb.push_back(w);
  endtask

  // Returns #1 after the edge that samples start (DUT then in READ).
  task automatic applyStimulus(input logic [4:0] first, input logic [4:0] last);
    @(posedge clock);
    #1;
    start = 1'b1;
    first_reg = first;
    last_reg = last;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic waitValid(input string name);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput(name, out_valid, 1'b1);
  endtask

  task automatic waitDone(input int target, input string name);
    int n = 0;
    while (done_count < target && n < 300) begin
      @(posedge clock);
      #1;
      n++;
    end
    @(posedge clock);
    #1;
    checkOutput(name, done_count, target);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] snap_data;
    logic [4:0]  snap_idx;
    logic        snap_last;
    int          unstable;

    for (int i = 0; i < 32; i++) regs[i] = 64'h1000 * i + 64'h11;
    reset = 1'b1;
    start = 1'b0;
    first_reg = '0;
    last_reg = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_outs", {rf_addr, out_data, out_index, out_last}, 0);
    reset = 1'b0;

    // Basic three-word dump with latency checks
    regs[1] = 64'd5; regs[2] = 64'd7; regs[3] = 64'd9;
    out_ready = 1'b1;
    pushWord(5'd1, 64'd5, 1'b0);
    pushWord(5'd2, 64'd7, 1'b0);
    pushWord(5'd3, 64'd9, 1'b1);
    applyStimulus(5'd1, 5'd3);
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_lat_read", out_valid, 0);
    @(posedge clock);
    #1;
    checkOutput("t1_lat_send", out_valid, 1);
    waitDone(1, "t1_done");
    checkOutput("t1_done_lat", done_cycle - last_hs_cycle, 1);
    checkOutput("t1_q_empty", sb.size(), 0);

    // Backpressure hold
    regs[1] = 64'h11; regs[2] = 64'h22; regs[3] = 64'h33;
    out_ready = 1'b0;
    pushWord(5'd1, 64'h11, 1'b0);
    pushWord(5'd2, 64'h22, 1'b0);
    pushWord(5'd3, 64'h33, 1'b1);
    applyStimulus(5'd1, 5'd3);
    waitValid("t2_valid");
    snap_data = out_data;
    snap_idx = out_index;
    snap_last = out_last;
    unstable = 0;
    repeat (10) begin
      @(posedge clock);
      #1;
      if (!out_valid || out_data !== snap_data || out_index !== snap_idx || out_last !== snap_last)
        unstable++;
    end
    checkOutput("t2_hold", unstable, 0);
    checkOutput("t2_hold_word", {out_index, out_data}, {5'd1, 64'h11});
    out_ready = 1'b1;
    waitDone(2, "t2_done");
    checkOutput("t2_q_empty", sb.size(), 0);

    // Wrap-around 30..1
    regs[30] = 64'hAAA; regs[31] = 64'hBBB; regs[0] = 64'hCCC; regs[1] = 64'hDDD;
    pushWord(5'd30, 64'hAAA, 1'b0);
    pushWord(5'd31, 64'hBBB, 1'b0);
    pushWord(5'd0, 64'hCCC, 1'b0);
    pushWord(5'd1, 64'hDDD, 1'b1);
    applyStimulus(5'd30, 5'd1);
    waitDone(3, "t3_done");
    checkOutput("t3_q_empty", sb.size(), 0);

    // Single word, start pulsed while busy
    regs[12] = 64'hDEAD;
    out_ready = 1'b0;
    pushWord(5'd12, 64'hDEAD, 1'b1);
    applyStimulus(5'd12, 5'd12);
    @(posedge clock);
    #1;
    start = 1'b1;
    first_reg = 5'd0;
    last_reg = 5'd31;
    @(posedge clock);
    #1;
    start = 1'b0;
    waitValid("t4_valid");
    out_ready = 1'b1;
    waitDone(4, "t4_done");
    repeat (5) @(posedge clock);
    #1;
    checkOutput("t4_single_done", done_count, 4);
    checkOutput("t4_idle", busy, 0);
    checkOutput("t4_q_empty", sb.size(), 0);

    // Reset during SEND of the second word
    regs[1] = 64'h101; regs[2] = 64'h202; regs[3] = 64'h303;
    out_ready = 1'b0;
    pushWord(5'd1, 64'h101, 1'b0);
    applyStimulus(5'd1, 5'd3);
    waitValid("t5_w1");
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    waitValid("t5_w2");
    checkOutput("t5_w2_index", out_index, 2);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t5_rst_valid", out_valid, 0);
    checkOutput("t5_rst_busy", busy, 0);
    checkOutput("t5_rst_outs", {rf_addr, out_data, out_index, out_last, done}, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    checkOutput("t5_no_done", done_count, 4);
    checkOutput("t5_q_empty", sb.size(), 0);
    out_ready = 1'b1;
    pushWord(5'd1, 64'h101, 1'b0);
    pushWord(5'd2, 64'h202, 1'b0);
    pushWord(5'd3, 64'h303, 1'b1);
    applyStimulus(5'd1, 5'd3);
    waitDone(5, "t5_fresh_done");
    checkOutput("t5_fresh_q_empty", sb.size(), 0);

    // Zero-valued registers
    regs[4] = 64'd0; regs[5] = 64'd3; regs[6] = 64'd0;
`ifdef REGDUMP_SKIP_ZERO_EN
    pushWord(5'd5, 64'd3, 1'b0);
`else
    pushWord(5'd4, 64'd0, 1'b0);
    pushWord(5'd5, 64'd3, 1'b0);
    pushWord(5'd6, 64'd0, 1'b1);
`endif
    applyStimulus(5'd4, 5'd6);
    waitDone(6, "t6_done");
    repeat (3) @(posedge clock);
    #1;
    checkOutput("t6_single_done", done_count, 6);
    checkOutput("t6_q_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
